// File: rtl/ctl_reg_scanner_if.sv
// Signal bundle between ctl_reg_scanner and its environment: controller BRAM port-B,
// the live FPGA state word and the config-word stream toward the config latches.
interface ctl_reg_scanner_if;
  logic [7:0]  bram_addr;
  logic [15:0] bram_rd_data;
  logic        bram_we;
  logic [15:0] bram_wr_data;
  logic [15:0] fpga_state;
  logic        cfg_valid;
  logic [2:0]  cfg_group;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_done;
  logic        force_fan;

  modport master (
    output bram_addr, bram_we, bram_wr_data,
    output cfg_valid, cfg_group, cfg_addr, cfg_data, cfg_done, force_fan,
    input  bram_rd_data, fpga_state
  );

  modport slave (
    input  bram_addr, bram_we, bram_wr_data,
    input  cfg_valid, cfg_group, cfg_addr, cfg_data, cfg_done, force_fan,
    output bram_rd_data, fpga_state
  );
endinterface

// File: rtl/ctl_reg_scanner.sv
// Scans the host CtlFlag word, streams toggled register groups out of the controller BRAM and
// writes FPGA state back. Define CTL_REG_VERSION_WB_EN to write the version words after reset.
module ctl_reg_scanner #(
  parameter int unsigned RdLatency = 2
) (
  input logic               clk,
  input logic               rst_n,
  ctl_reg_scanner_if.master bus
);

  typedef enum logic [2:0] {
    StRdCtl, StCheck, StFetch, StDone, StWrSt, StVerStart, StVerMaj, StVerMin
  } state_e;

`ifdef CTL_REG_VERSION_WB_EN
  localparam state_e StReset = StVerStart;
`else
  localparam state_e StReset = StRdCtl;
`endif

  localparam logic [7:0]  AddrCtlFlag  = 8'h00;
  localparam logic [7:0]  AddrFpgaSt   = 8'h01;
  localparam logic [7:0]  AddrVerMajor = 8'h30;
  localparam logic [7:0]  AddrVerMinor = 8'h31;
  localparam logic [15:0] VerMajor     = 16'h0090;
  localparam logic [15:0] VerMinor     = 16'h0000;

  function automatic logic [7:0] grp_start(logic [2:0] g);
    unique case (g)
      3'd0:    return 8'h20;
      3'd1:    return 8'h50;
      3'd2:    return 8'h40;
      3'd3:    return 8'hE0;
      3'd4:    return 8'hF0;
      3'd5:    return 8'h11;
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] grp_end(logic [2:0] g);
    unique case (g)
      3'd0:    return 8'h2B;
      3'd1:    return 8'h63;
      3'd2:    return 8'h44;
      3'd3:    return 8'hE1;
      3'd4:    return 8'hF7;
      3'd5:    return 8'h14;
      default: return 8'h2B;
    endcase
  endfunction

  state_e                          state_q, state_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic [5:0]                      flag_q, flag_d;
  logic                            force_fan_q, force_fan_d;
  logic [5:0]                      handled_q, handled_d;
  logic [2:0]                      grp_q, grp_d;
  logic [7:0]                      fetch_addr_q, fetch_addr_d;
  logic [RdLatency-1:0]            pipe_vld_q;
  logic [RdLatency-1:0][7:0]       pipe_addr_q;
  logic                            cfg_valid_q;
  logic [7:0]                      cfg_addr_q;
  logic [15:0]                     cfg_data_q;

  logic [5:0]  pending;
  logic [2:0]  low_grp;
  logic [7:0]  bram_addr;
  logic        bram_we;
  logic [15:0] bram_wr_data;
  logic        issue;
  logic        cfg_done;

  // Only the group bits and the fan bit of CtlFlag matter here.
  logic unused_flag_bits;
  assign unused_flag_bits = ^{bus.bram_rd_data[15:14], bus.bram_rd_data[12:6]};

  assign pending = flag_q ^ handled_q;

  always_comb begin
    low_grp = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending[i]) low_grp = 3'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    force_fan_d  = force_fan_q;
    handled_d    = handled_q;
    grp_d        = grp_q;
    fetch_addr_d = fetch_addr_q;
    bram_addr    = AddrCtlFlag;
    bram_we      = 1'b0;
    bram_wr_data = 16'h0000;
    issue        = 1'b0;
    cfg_done     = 1'b0;

    unique case (state_q)
      StRdCtl: begin
        cnt_d = cnt_q + 2'd1;
        // Address 0x00 has been held for RdLatency cycles, so the read data is the flag word.
        if (cnt_q == 2'(RdLatency)) begin
          cnt_d       = 2'd0;
          flag_d      = bus.bram_rd_data[5:0];
          force_fan_d = bus.bram_rd_data[13];
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (|pending) begin
          grp_d        = low_grp;
          bram_addr    = grp_start(low_grp);
          issue        = 1'b1;
          fetch_addr_d = grp_start(low_grp) + 8'd1;
          state_d      = StFetch;
        end else begin
          state_d = StWrSt;
        end
      end
      StFetch: begin
        if (fetch_addr_q <= grp_end(grp_q)) begin
          bram_addr    = fetch_addr_q;
          issue        = 1'b1;
          fetch_addr_d = fetch_addr_q + 8'd1;
        end else if (pipe_vld_q == '0) begin
          // Last word is on the cfg outputs this cycle.
          state_d = StDone;
        end
      end
      StDone: begin
        cfg_done           = 1'b1;
        handled_d[grp_q]   = flag_q[grp_q];
        state_d            = StRdCtl;
      end
      StWrSt: begin
        bram_addr    = AddrFpgaSt;
        bram_we      = 1'b1;
        bram_wr_data = bus.fpga_state;
        state_d      = StRdCtl;
      end
`ifdef CTL_REG_VERSION_WB_EN
      StVerStart: state_d = StVerMaj;
      StVerMaj: begin
        bram_addr    = AddrVerMajor;
        bram_we      = 1'b1;
        bram_wr_data = VerMajor;
        state_d      = StVerMin;
      end
      StVerMin: begin
        bram_addr    = AddrVerMinor;
        bram_we      = 1'b1;
        bram_wr_data = VerMinor;
        state_d      = StRdCtl;
      end
`endif
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StReset;
      cnt_q        <= 2'd0;
      flag_q       <= 6'd0;
      force_fan_q  <= 1'b0;
      handled_q    <= 6'd0;
      grp_q        <= 3'd0;
      fetch_addr_q <= 8'd0;
      pipe_vld_q   <= '0;
      pipe_addr_q  <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_addr_q   <= 8'd0;
      cfg_data_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      force_fan_q  <= force_fan_d;
      handled_q    <= handled_d;
      grp_q        <= grp_d;
      fetch_addr_q <= fetch_addr_d;
      // Tags ride alongside the BRAM read pipeline so data and address line up.
      pipe_vld_q[0]  <= issue;
      pipe_addr_q[0] <= bram_addr;
      for (int unsigned i = 1; i < RdLatency; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
      cfg_valid_q <= pipe_vld_q[RdLatency-1];
      if (pipe_vld_q[RdLatency-1]) begin
        cfg_addr_q <= pipe_addr_q[RdLatency-1];
        cfg_data_q <= bus.bram_rd_data;
      end
    end
  end

  assign bus.bram_addr    = bram_addr;
  assign bus.bram_we      = bram_we;
  assign bus.bram_wr_data = bram_wr_data;
  assign bus.cfg_valid    = cfg_valid_q;
  assign bus.cfg_group    = grp_q;
  assign bus.cfg_addr     = cfg_addr_q;
  assign bus.cfg_data     = cfg_data_q;
  assign bus.cfg_done     = cfg_done;
  assign bus.force_fan    = force_fan_q;

endmodule

// File: tb/tb_ctl_reg_scanner.sv
// Scoreboard bench for ctl_reg_scanner: a BRAM model feeds the DUT, a flag-level model predicts
// the config stream and write-backs, and a monitor compares everything the DUT presents.
module tb_ctl_reg_scanner;
  localparam int unsigned RL     = 2;
  localparam int unsigned Period = RL + 3;

  typedef struct packed {
    logic        done;
    logic [2:0]  grp;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] fpga_state;

  ctl_reg_scanner_if bus ();

  ctl_reg_scanner #(.RdLatency(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller BRAM model: fixed read latency; host side owned by the bench.
  logic [15:0] mem [256];
  logic [15:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.bram_addr];
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_rd_data = rd_pipe[RL-1];
  assign bus.fpga_state   = fpga_state;

  int unsigned g_lo [6] = '{32'h20, 32'h50, 32'h40, 32'hE0, 32'hF0, 32'h11};
  int unsigned g_hi [6] = '{32'h2B, 32'h63, 32'h44, 32'hE1, 32'hF7, 32'h14};

  exp_t        exp_q [$];
  exp_t        ver_q [$];
  logic [5:0]  m_handled;
  logic        m_fan;
  logic [15:0] cur_flag;
  int          n_checks = 0;
  int          n_bad    = 0;
  int unsigned cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Host writes CtlFlag: every group whose bit differs from what was already serviced
  // streams once, lowest index first, followed by its done pulse.
  task automatic apply_flag(input logic [15:0] f);
    logic [5:0] pend;
    exp_t       e;
    pend = f[5:0] ^ m_handled;
    for (int g = 0; g < 6; g++) begin
      if (pend[g]) begin
        for (int unsigned a = g_lo[g]; a <= g_hi[g]; a++) begin
          e.done = 1'b0;
          e.grp  = 3'(g);
          e.addr = 8'(a);
          e.data = mem[8'(a)];
          exp_q.push_back(e);
        end
        e.done = 1'b1;
        e.grp  = 3'(g);
        e.addr = 8'h00;
        e.data = 16'h0000;
        exp_q.push_back(e);
      end
    end
    m_handled = f[5:0];
    m_fan     = f[13];
    cur_flag  = f;
    mem[0]    = f;
  endtask

  task automatic load_ver();
    exp_t e;
    ver_q.delete();
`ifdef CTL_REG_VERSION_WB_EN
    e.done = 1'b0; e.grp = 3'd0; e.addr = 8'h30; e.data = 16'h0090;
    ver_q.push_back(e);
    e.addr = 8'h31; e.data = 16'h0000;
    ver_q.push_back(e);
`else
    e = '0;
    if (e.done) ver_q.push_back(e);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic settle();
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget != 0) begin
      step();
      budget--;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    idle(3 * int'(Period) + 2);
    check("force_fan", 32'(bus.force_fan), 32'(m_fan));
  endtask

  task automatic check_reset_outputs();
    check("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    check("rst_bram_we", 32'(bus.bram_we), 32'd0);
    check("rst_bram_wr_data", 32'(bus.bram_wr_data), 32'd0);
    check("rst_cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("rst_cfg_group", 32'(bus.cfg_group), 32'd0);
    check("rst_cfg_addr", 32'(bus.cfg_addr), 32'd0);
    check("rst_cfg_data", 32'(bus.cfg_data), 32'd0);
    check("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    check("rst_force_fan", 32'(bus.force_fan), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a word or done pulse.
  logic        expect_next = 1'b0;
  logic        have_we     = 1'b0;
  logic        quiet       = 1'b0;
  int unsigned last_we     = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expect_next <= 1'b0;
      have_we     <= 1'b0;
      quiet       <= 1'b0;
    end else begin
      if (expect_next) check("cfg_gap", 32'(bus.cfg_valid | bus.cfg_done), 32'd1);
      if (bus.cfg_valid || bus.cfg_done) begin
        quiet <= 1'b0;
        if (exp_q.size() == 0) begin
          check("cfg_unexpected", 32'({bus.cfg_valid, bus.cfg_done}), 32'd0);
          expect_next <= 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("cfg_kind", 32'({bus.cfg_valid, bus.cfg_done}), 32'({~e.done, e.done}));
          check("cfg_group", 32'(bus.cfg_group), 32'(e.grp));
          if (!e.done) begin
            check("cfg_addr", 32'(bus.cfg_addr), 32'(e.addr));
            check("cfg_data", 32'(bus.cfg_data), 32'(e.data));
          end
          expect_next <= !e.done;
        end
      end else begin
        expect_next <= 1'b0;
      end
      if (bus.bram_we) begin
        if (ver_q.size() != 0) begin
          e = ver_q.pop_front();
          check("ver_addr", 32'(bus.bram_addr), 32'(e.addr));
          check("ver_data", 32'(bus.bram_wr_data), 32'(e.data));
        end else begin
          check("wb_addr", 32'(bus.bram_addr), 32'h01);
          check("wb_data", 32'(bus.bram_wr_data), 32'(fpga_state));
          if (have_we && quiet) check("wb_period", cyc - last_we, Period);
        end
        have_we <= 1'b1;
        last_we <= cyc;
        quiet   <= 1'b1;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    fpga_state = 16'h00A5;
    m_handled  = 6'd0;
    m_fan      = 1'b0;
    cur_flag   = 16'h0000;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h0000;
    for (int i = 0; i < 5; i++) mem[8'h40 + i] = 16'(i + 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    step();
    load_ver();
    rst_n = 1'b1;

    // Flag clear: only periodic state write-back.
    idle(4 * int'(Period) + 3);
    check("idle_no_stream", 32'(exp_q.size()), 32'd0);

    apply_flag(16'h0004);   // silencer, data 1..5
    settle();
    apply_flag(16'h0007);   // mod then stm (silencer bit unchanged)
    settle();
    apply_flag(16'h0006);   // mod bit back to 0: toggle re-streams mod
    settle();
    apply_flag(16'h2006);   // fan only, no stream
    settle();
    apply_flag(16'h0006);
    settle();

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 8; k++) mem[8'($urandom_range(16, 255))] = 16'($urandom);
      fpga_state = 16'($urandom);
      apply_flag(16'($urandom));
      settle();
    end

    // Reset in the middle of an stm stream: aborted, then re-streamed from handled=0.
    begin
      int budget;
      apply_flag(cur_flag ^ 16'h0002);
      budget = 200;
      while (exp_q.size() > 14 && budget != 0) begin
        step();
        budget--;
      end
      check("stm_started", 32'(exp_q.size() <= 14), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      m_handled = 6'd0;
      m_fan     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      step();
      load_ver();
      rst_n = 1'b1;
      apply_flag(cur_flag);
      settle();
    end

    check("ver_left", 32'(ver_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
